// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a 16-entry melody pattern at a programmable
// tempo and drives the note/octave/enable controls of the tone generator.
// Build option: define TONE_SEQ_LOOP_EN to restart at entry 0 after an entry
// flagged "last" instead of returning to idle.
module tone_sequencer #(
   parameter int PRESCALE  = 10000,
   parameter int GAP_TICKS = 1,
   parameter int TEMPO_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena_i,
   input  logic               wr_en_i,
   input  logic [3:0]         wr_addr_i,
   input  logic [7:0]         wr_data_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [TEMPO_W-1:0] tempo_div_i,
   output logic [3:0]         note_sel_o,
   output logic [1:0]         octave_sel_o,
   output logic               tone_en_o,
   output logic               busy_o,
   output logic [3:0]         step_idx_o,
   output logic               step_pulse_o
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [31:0] GapTicks = 32'(GAP_TICKS);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

   state_t               state_q;
   logic [7:0]           mem_q [16];
   logic [PW-1:0]        presc_q;
   logic [TEMPO_W-1:0]   tick_q;
   logic [TEMPO_W-1:0]   tempo_q;
   logic [3:0]           note_q;
   logic [1:0]           octave_q;
   logic                 last_q;
   logic                 tone_en_q;
   logic [3:0]           step_idx_q;
   logic                 step_pulse_q;

   logic [31:0]          stepTicks;
   logic [31:0]          tickInc;
   logic                 prescWrap;
   logic                 stepEnd;
   logic                 gapEnter;
   logic                 fetchEn;
   logic                 goIdle;
   logic [3:0]           fetchIdx;
   logic [7:0]           fetchData;

   // Pattern memory: host writes land in any state, even while frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign fetchData = mem_q[fetchIdx];

   // Step timing: end of step and the point where the articulation gap begins.
   always_comb begin
      stepTicks = 32'(tempo_q) + 32'd1;
      tickInc   = 32'(tick_q) + 32'd1;
      prescWrap = (presc_q == PW'(PRESCALE - 1));
      stepEnd   = prescWrap && (tick_q == tempo_q);
      gapEnter  = prescWrap && !stepEnd && (stepTicks > GapTicks)
                  && (tickInc == stepTicks - GapTicks);
   end

   // Decide whether this cycle fetches a new entry or drops back to idle.
   always_comb begin
      fetchEn  = 1'b0;
      goIdle   = 1'b0;
      fetchIdx = 4'd0;
      if (stop_i) begin
         goIdle = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  fetchEn  = 1'b1;
                  fetchIdx = 4'd0;
               end
            end
            default: begin
               if (stepEnd) begin
                  if (last_q) begin
`ifdef TONE_SEQ_LOOP_EN
                     fetchEn  = 1'b1;
                     fetchIdx = 4'd0;
`else
                     goIdle   = 1'b1;
`endif
                  end else begin
                     fetchEn  = 1'b1;
                     fetchIdx = step_idx_q + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   // Sequencer FSM with registered outputs; ena_i low freezes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         tick_q       <= '0;
         tempo_q      <= '0;
         note_q       <= '0;
         octave_q     <= '0;
         last_q       <= 1'b0;
         tone_en_q    <= 1'b0;
         step_idx_q   <= '0;
         step_pulse_q <= 1'b0;
      end else if (ena_i) begin
         step_pulse_q <= 1'b0;
         if (goIdle) begin
            state_q   <= IDLE;
            tone_en_q <= 1'b0;
         end else if (fetchEn) begin
            state_q      <= PLAY;
            step_idx_q   <= fetchIdx;
            note_q       <= fetchData[3:0];
            octave_q     <= fetchData[5:4];
            tone_en_q    <= !fetchData[6];
            last_q       <= fetchData[7];
            tempo_q      <= tempo_div_i;
            step_pulse_q <= 1'b1;
            presc_q      <= '0;
            tick_q       <= '0;
         end else if (state_q != IDLE) begin
            if (prescWrap) begin
               presc_q <= '0;
               tick_q  <= tick_q + TEMPO_W'(1);
               if (gapEnter) begin
                  state_q   <= GAP;
                  tone_en_q <= 1'b0;
               end
            end else begin
               presc_q <= presc_q + PW'(1);
            end
         end
      end else begin
         step_pulse_q <= 1'b0;
      end
   end

   assign note_sel_o   = note_q;
   assign octave_sel_o = octave_q;
   assign tone_en_o    = tone_en_q;
   assign busy_o       = (state_q != IDLE);
   assign step_idx_o   = step_idx_q;
   assign step_pulse_o = step_pulse_q & ena_i;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Melody sequencer that drives the note/octave/enable controls of the square-wave tone generator from a 16-entry programmable pattern memory.
- Steps through the pattern at a programmable tempo.
- Inserts an articulation gap (silence) at the end of each step.
- Stops, or optionally loops, at an entry flagged "last".
- Sits between the host-facing pin/register interface and the tone generator, replacing direct pin control of note selection.

Parameters:
PRESCALE, 10000, clk cycles per tempo tick (1 ms at 10 MHz); must be >= 2
GAP_TICKS, 1, ticks of forced silence at the end of each step
TEMPO_W, 8, width of tempo_div

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; low freezes all state
wr_en  in  1  pattern write strobe
wr_addr  in  4  pattern entry index
wr_data  in  8  entry: [3:0] note, [5:4] octave, [6] rest, [7] last
start  in  1  single-cycle start request
stop  in  1  single-cycle stop request
tempo_div  in  TEMPO_W  step length minus 1, in ticks
note_sel  out  4  note index to the tone generator
octave_sel  out  2  octave to the tone generator
tone_en  out  1  tone generator enable
busy  out  1  high while not IDLE
step_idx  out  4  index of the current entry
step_pulse  out  1  one-cycle pulse at the start of each step

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Prescaler and tick counters 0.
  - All 16 pattern entries 0.
- Pattern memory:
  - wr_en=1 writes wr_data to entry wr_addr on the clk edge.
  - Writes are accepted in any state and regardless of ena.
  - A write to the entry currently playing does not change the latched outputs; it takes effect the next time that entry is fetched.
- States: IDLE, PLAY, GAP.
- IDLE:
  - tone_en=0; note_sel, octave_sel and step_idx hold their last values.
  - start=1 and stop=0 -> next cycle: PLAY, step_idx=0, fetch entry 0.
- Step fetch (entry k), all in the same cycle:
  - Latch note_sel, octave_sel, the rest bit, the last bit, and tempo_div (sampled once per step).
  - Set tone_en = !rest.
  - Pulse step_pulse for 1 cycle.
  - Clear prescaler and tick counter.
- Step length: exactly (tempo_div+1)*PRESCALE clk cycles, measured from the fetch cycle to the next fetch cycle.
- Gap:
  - If tempo_div+1 > GAP_TICKS: PLAY -> GAP when the tick count reaches tempo_div+1-GAP_TICKS. tone_en=0 in GAP.
  - Otherwise there is no gap: the whole step stays in PLAY.
- End of step:
  - Entry without last bit: fetch entry (k+1) mod 16. Index 15 wraps to 0.
  - Entry with last bit: go to IDLE, or loop per the optional feature.
- Request handling:
  - stop=1 in any state -> IDLE next cycle, tone_en=0.
  - stop wins over a simultaneous start.
  - start while busy is ignored.
- ena=0:
  - Counters, state and outputs freeze; step_pulse is forced to 0.
  - start and stop are ignored.
- Async reset mid-play: immediately returns all outputs and state to the reset values; the pattern is cleared.

Optional Feature:
TONE_SEQ_LOOP_EN.
- Defined: at the end of a step whose entry has the last bit set, fetch entry 0 and continue playing. busy stays 1, and step_pulse fires on the entry 0 fetch.
- Undefined: the last-flagged step ends in IDLE with busy=0 and tone_en=0.
- Stop behaviour is identical in both builds.

Test Plan:
All scenarios use PRESCALE=4 and GAP_TICKS=1.
1. Basic playback:
   - Stimulus: write entry0=0x09, entry1=0x94 (last); tempo_div=3; pulse start.
   - Required response: step_pulse at fetch cycles t and t+16. note_sel=9 then 4, octave_sel=0 then 1. tone_en high 12 cycles then low 4 in each step. busy drops at t+32 (non-loop build).
2. Rest entry:
   - Stimulus: entry0=0x40, entry1=0x81; tempo_div=1.
   - Required response: tone_en=0 for all of step 0. note_sel=1 and tone_en=1 for 4 cycles of step 1.
3. No-gap boundary:
   - Stimulus: tempo_div=0.
   - Required response: each step is 4 cycles, tone_en stays high for the whole step, and the state never enters GAP.
4. Stop/start precedence:
   - Stimulus: stop mid-step 0; separately, start and stop asserted together in IDLE.
   - Required response: busy=0 and tone_en=0 on the next cycle in the first case; state stays IDLE in the second.
5. Wrap without last and ena freeze:
   - Stimulus: all 16 entries without the last bit; hold ena=0 for 10 cycles mid-step.
   - Required response: step_idx goes 15 -> 0. That step is extended by exactly 10 cycles, with outputs unchanged during the freeze.
6. Loop build (TONE_SEQ_LOOP_EN):
   - Stimulus: same pattern as scenario 1.
   - Required response: entry0 is refetched at t+32 with step_pulse, and busy stays 1.
